hilo_writeback: RTL and testbench
=================================

HILO_WRITEBACK -- requirements
Module: hilo_writeback

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the datapath word width; HI, LO, bus and divisor are WIDTH bits and z_in is 2*WIDTH bits.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port clr, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to capture z_in for writeback.
REQ-005 The block SHALL have port op_div, input, 1 bit: 1 = z_in comes from the divider, 0 = z_in comes from the multiplier.
REQ-006 The block SHALL have port z_in, input, 2*WIDTH bits: arithmetic result, with {remainder, quotient} for divide and {high product, low product} for multiply.
REQ-007 The block SHALL have port divisor, input, WIDTH bits: divisor operand, sampled with start.
REQ-008 The block SHALL have port bus_grant, input, 1 bit: shared-bus grant for the current drive request.
REQ-009 The block SHALL have port bus_drive, output, 1 bit: request to drive bus_out onto the shared bus.
REQ-010 The block SHALL have port bus_out, output, WIDTH bits: word being written back.
REQ-011 The block SHALL have ports hi_out and lo_out, output, WIDTH bits each: architectural HI and LO registers.
REQ-012 The block SHALL have ports busy and done, output, 1 bit each: operation in progress, and one-cycle completion pulse.
REQ-013 The block SHALL have port div0_flag, output, 1 bit: sticky divide-by-zero indicator.

Function
REQ-014 The FSM SHALL have states IDLE, WR_LO, WR_HI and DONE.
REQ-015 In IDLE, start=1 SHALL latch z_in into internal registers zh (upper half) and zl (lower half), sample op_div and divisor, and move the FSM to WR_LO.
REQ-016 In WR_LO, bus_drive SHALL be 1 and bus_out SHALL equal zl; on the edge where bus_grant=1, lo_out SHALL load zl and the FSM SHALL move to WR_HI; while bus_grant=0 the FSM SHALL hold in WR_LO.
REQ-017 In WR_HI, bus_drive SHALL be 1 and bus_out SHALL equal zh; on the edge where bus_grant=1, hi_out SHALL load zh and the FSM SHALL move to DONE.
REQ-018 In DONE, done SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-019 busy SHALL be 1 in WR_LO, WR_HI and DONE, and 0 in IDLE.
REQ-020 In IDLE and DONE, bus_drive SHALL be 0 and bus_out SHALL be all zeros.
REQ-021 start SHALL be ignored while busy=1; z_in changes after capture SHALL NOT affect the writeback.
REQ-022 With bus_grant held at 1, start sampled at edge N SHALL produce lo_out updated at edge N+1, hi_out updated at edge N+2, and done=1 in cycle N+3; start is accepted again from cycle N+4.
REQ-023 For divide, HI SHALL be the remainder (z_in upper half) and LO the quotient (z_in lower half); for multiply, HI/LO SHALL be the high/low product halves; no arithmetic is applied to the data.
REQ-024 hi_out and lo_out SHALL change only on the grant edges defined in REQ-016 and REQ-017, or on reset.

Reset
REQ-025 When clr=1 at a clock edge, regardless of state or start, the FSM SHALL go to IDLE and hi_out, lo_out, zh, zl and div0_flag SHALL be cleared to 0.
REQ-026 Outputs implied by IDLE SHALL apply after reset: busy=0, done=0, bus_drive=0, bus_out=0.
REQ-027 A reset mid-operation SHALL abandon the operation with no done pulse.

Configuration
REQ-028 Macro HILO_DIV0_TRAP_EN SHALL compile divide-by-zero trapping in or out.
REQ-029 With HILO_DIV0_TRAP_EN defined, a start with op_div=1 and divisor=0 SHALL set div0_flag, go directly IDLE->DONE without driving the bus or altering hi_out/lo_out, and pulse done; div0_flag SHALL stay set until clr or the next accepted start with a nonzero divisor or op_div=0.
REQ-030 Without HILO_DIV0_TRAP_EN, div0_flag SHALL be constant 0, and divide-by-zero results SHALL be written back like any other result.

Verification
REQ-031 The bench SHALL cover: start, op_div=1, z_in={32'd2,32'd14} (100/7), grant=1 -> lo_out=14 at N+1, hi_out=2 at N+2, done in N+3.
REQ-032 The bench SHALL cover: grant=0 for 5 cycles in WR_LO -> bus_out=zl and bus_drive=1 held, lo_out unchanged, done 5 cycles later.
REQ-033 The bench SHALL cover: start pulsed in WR_HI with new z_in=64'hFFFF... -> ignored, and hi_out equals the originally captured value.
REQ-034 The bench SHALL cover: clr asserted in WR_HI -> next cycle IDLE, busy=0, hi_out=lo_out=0, and no done pulse.
REQ-035 The bench SHALL cover, with HILO_DIV0_TRAP_EN: op_div=1, divisor=0 -> div0_flag=1, bus_drive never 1, hi_out/lo_out unchanged, done in N+1; a following multiply start -> div0_flag=0.
REQ-036 The bench SHALL cover: a multiply with z_in=64'h0000_0001_8000_0000 -> hi_out=32'h1, lo_out=32'h8000_0000.

Source files
------------

// File: rtl/hilo_writeback.sv
// hilo_writeback: captures a 2*WIDTH multiply/divide result and writes LO then HI over a granted shared bus.
// Optional HILO_DIV0_TRAP_EN skips the writeback on divide-by-zero and raises a sticky div0_flag.
module hilo_writeback #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               start,
   input  logic               op_div,
   input  logic [2*WIDTH-1:0] z_in,
   input  logic [WIDTH-1:0]   divisor,
   input  logic               bus_grant,
   output logic               bus_drive,
   output logic [WIDTH-1:0]   bus_out,
   output logic [WIDTH-1:0]   hi_out,
   output logic [WIDTH-1:0]   lo_out,
   output logic               busy,
   output logic               done,
   output logic               div0_flag
);
   typedef enum logic [1:0] {IDLE, WR_LO, WR_HI, DONE} state_t;
   state_t state, state_nx;
   logic [WIDTH-1:0] zh, zl;
   logic trap;
`ifdef HILO_DIV0_TRAP_EN
   assign trap = op_div && (divisor == '0);
`else
   logic unused_div;
   assign unused_div = ^{op_div, divisor};
   assign trap = 1'b0;
`endif
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = start ? (trap ? DONE : WR_LO) : IDLE;
         WR_LO:   state_nx = bus_grant ? WR_HI : WR_LO;
         WR_HI:   state_nx = bus_grant ? DONE : WR_HI;
         default: state_nx = IDLE;
      endcase
   end
   assign busy      = state != IDLE;
   assign done      = state == DONE;
   assign bus_drive = (state == WR_LO) || (state == WR_HI);
   assign bus_out   = (state == WR_LO) ? zl : (state == WR_HI) ? zh : '0;
   // trap is constant 0 without the macro, so div0_flag never leaves reset
   always_ff @(posedge clk) begin
      if (clr) begin
         state     <= IDLE;
         zh        <= '0;
         zl        <= '0;
         hi_out    <= '0;
         lo_out    <= '0;
         div0_flag <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && start) begin
            {zh, zl}  <= z_in;
            div0_flag <= trap;
         end
         if (state == WR_LO && bus_grant) lo_out <= zl;
         if (state == WR_HI && bus_grant) hi_out <= zh;
      end
   end
endmodule

// File: tb/tb_hilo_writeback.sv
// tb_hilo_writeback: directed vectors; a done-triggered monitor checks HI/LO/div0 against a queue of expected results.
module tb_hilo_writeback;
   localparam int W = 32;
   logic clk = 0, clr = 1, start = 0, op_div = 0, bus_grant = 1;
   logic [2*W-1:0] z_in = '0;
   logic [W-1:0] divisor = '0;
   logic bus_drive, busy, done, div0_flag;
   logic [W-1:0] bus_out, hi_out, lo_out;
   logic [2*W:0] exp_q[$];
   int total = 0, bad = 0;

   hilo_writeback #(.WIDTH(W)) dut (
      .clk(clk), .clr(clr), .start(start), .op_div(op_div), .z_in(z_in),
      .divisor(divisor), .bus_grant(bus_grant), .bus_drive(bus_drive),
      .bus_out(bus_out), .hi_out(hi_out), .lo_out(lo_out), .busy(busy),
      .done(done), .div0_flag(div0_flag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic od, input logic [2*W-1:0] z, input logic [W-1:0] d);
      start = 1; op_div = od; z_in = z; divisor = d;
      tick();
      start = 0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 20) begin
         tick();
         n++;
      end
      chk("done_seen", 64'(done), 64'd1);
      tick();
   endtask

   // monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (done) begin
         if (exp_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
         else begin
            logic [2*W:0] e;
            e = exp_q.pop_front();
            chk("mon_hi", 64'(hi_out), 64'(e[2*W:W+1]));
            chk("mon_lo", 64'(lo_out), 64'(e[W:1]));
            chk("mon_div0", 64'(div0_flag), 64'(e[0]));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      tick(); tick();
      clr = 0;
      chk("rst_busy", 64'(busy), 0);
      chk("rst_done", 64'(done), 0);
      chk("rst_drive", 64'(bus_drive), 0);
      chk("rst_bus", 64'(bus_out), 0);
      chk("rst_hi", 64'(hi_out), 0);
      chk("rst_lo", 64'(lo_out), 0);
      chk("rst_div0", 64'(div0_flag), 0);
      // 100/7: remainder 2, quotient 14, grant always on
      exp_q.push_back({32'd2, 32'd14, 1'b0});
      do_start(1, {32'd2, 32'd14}, 32'd7);
      chk("div_drive_lo", 64'(bus_drive), 1);
      chk("div_bus_lo", 64'(bus_out), 14);
      chk("div_lo_n", 64'(lo_out), 0);
      tick();
      chk("div_lo_n1", 64'(lo_out), 14);
      chk("div_hi_n1", 64'(hi_out), 0);
      chk("div_bus_hi", 64'(bus_out), 2);
      tick();
      chk("div_hi_n2", 64'(hi_out), 2);
      chk("div_done_n3", 64'(done), 1);
      chk("div_drive_done", 64'(bus_drive), 0);
      tick();
      chk("div_done_off", 64'(done), 0);
      chk("div_idle_busy", 64'(busy), 0);
      // grant withheld for 5 cycles in WR_LO
      bus_grant = 0;
      exp_q.push_back({32'h1234_5678, 32'h9abc_def0, 1'b0});
      do_start(0, {32'h1234_5678, 32'h9abc_def0}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         chk("stall_drive", 64'(bus_drive), 1);
         chk("stall_bus", 64'(bus_out), 64'h9abc_def0);
         chk("stall_lo", 64'(lo_out), 14);
         chk("stall_done", 64'(done), 0);
         tick();
      end
      bus_grant = 1;
      wait_done();
      // start in WR_HI with all-ones data must be ignored
      exp_q.push_back({32'haaaa_0001, 32'h5555_0002, 1'b0});
      do_start(0, {32'haaaa_0001, 32'h5555_0002}, 32'd0);
      tick();
      start = 1; z_in = '1;
      tick();
      start = 0;
      chk("ign_hi", 64'(hi_out), 64'haaaa_0001);
      tick();
      chk("ign_busy", 64'(busy), 0);
      tick();
      chk("ign_still_idle", 64'(busy), 0);
      // reset in WR_HI abandons the operation
      do_start(0, {32'h1111, 32'h2222}, 32'd0);
      tick();
      chk("clr_pre_lo", 64'(lo_out), 64'h2222);
      clr = 1;
      tick();
      clr = 0;
      chk("clr_busy", 64'(busy), 0);
      chk("clr_hi", 64'(hi_out), 0);
      chk("clr_lo", 64'(lo_out), 0);
      chk("clr_drive", 64'(bus_drive), 0);
      chk("clr_bus", 64'(bus_out), 0);
      chk("clr_done", 64'(done), 0);
      tick(); tick(); tick();
      // multiply halves written unchanged
      exp_q.push_back({32'h1, 32'h8000_0000, 1'b0});
      do_start(0, 64'h0000_0001_8000_0000, 32'd0);
      wait_done();
`ifdef HILO_DIV0_TRAP_EN
      exp_q.push_back({32'h1, 32'h8000_0000, 1'b1});
      do_start(1, 64'hdead_beef_cafe_f00d, 32'd0);
      chk("trap_drive", 64'(bus_drive), 0);
      chk("trap_flag", 64'(div0_flag), 1);
      chk("trap_done_n1", 64'(done), 1);
      tick();
      chk("trap_drive_after", 64'(bus_drive), 0);
      chk("trap_hi", 64'(hi_out), 1);
      chk("trap_flag_sticky", 64'(div0_flag), 1);
      exp_q.push_back({32'h3, 32'h4, 1'b0});
      do_start(0, {32'h3, 32'h4}, 32'd0);
      chk("trap_flag_clear", 64'(div0_flag), 0);
      wait_done();
`else
      exp_q.push_back({32'h5, 32'h6, 1'b0});
      do_start(1, {32'h5, 32'h6}, 32'd0);
      chk("div0_drive", 64'(bus_drive), 1);
      chk("div0_flag_off", 64'(div0_flag), 0);
      wait_done();
`endif
      tick(); tick();
      chk("queue_empty", 64'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
